// File: rtl/message_to_packet_queue_pkg.sv
// Shared widths and types for the MESSAGE2PACKET queue.
// Bus, flit and packet sizing lives here so the interface, the queue and the bench all agree.
package message_to_packet_queue_pkg;

    localparam int BUS_ADDRESS_WIDTH = 32;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int BUS_SEL_WIDTH     = 4;
    localparam int FLIT_WIDTH        = 32;
    localparam int MAX_PACKET_LENGHT = 5;
    localparam int MAX_BURST_LENGHT  = 4;
    localparam int QUEUE_WIDTH       = 4;

    localparam int CHUNKS_PER_FLIT   = FLIT_WIDTH / BUS_DATA_WIDTH;
    localparam int PACKET_WIDTH      = MAX_PACKET_LENGHT * FLIT_WIDTH;

    // A head flit plus a full burst must fit in one packet.
    localparam bit PACKING_FITS =
        (FLIT_WIDTH + MAX_BURST_LENGHT * BUS_DATA_WIDTH <= PACKET_WIDTH) &&
        (CHUNKS_PER_FLIT >= 1) && (BUS_ADDRESS_WIDTH <= FLIT_WIDTH);

    typedef logic [BUS_ADDRESS_WIDTH-1:0] addr_t;
    typedef logic [BUS_DATA_WIDTH-1:0]    chunk_t;
    typedef logic [BUS_SEL_WIDTH-1:0]     bsel_t;
    typedef logic [PACKET_WIDTH-1:0]      packet_t;
    typedef logic [MAX_PACKET_LENGHT-1:0] flit_sel_t;

endpackage

// File: rtl/message_to_packet_queue_if.sv
// Bus-side slave signals and the NoC-side request/grant port of the queue.
// The queue takes the slave modport; the bus/port logic driving it takes master.
interface message_to_packet_queue_if;
    import message_to_packet_queue_pkg::*;

    logic      store_i;
    addr_t     address_i;
    chunk_t    data_i;
    bsel_t     sel_i;
    logic      message_end_i;
    logic      abort_i;
    logic      free_slot_o;
    packet_t   out_link_o;
    flit_sel_t out_sel_o;
    logic      r_msg_to_pkt_o;
    logic      g_msg_to_pkt_i;

    modport slave (
        input  store_i, address_i, data_i, sel_i, message_end_i, abort_i, g_msg_to_pkt_i,
        output free_slot_o, out_link_o, out_sel_o, r_msg_to_pkt_o
    );

    modport master (
        output store_i, address_i, data_i, sel_i, message_end_i, abort_i, g_msg_to_pkt_i,
        input  free_slot_o, out_link_o, out_sel_o, r_msg_to_pkt_o
    );

endinterface

// File: rtl/message_to_packet_queue.sv
// Assembles bus messages chunk by chunk into packet slots and hands complete packets,
// in FIFO order, to the output port through a request/grant handshake.
module message_to_packet_queue
    import message_to_packet_queue_pkg::*;
#(
    parameter int N_BITS_POINTER      = 3,
    parameter int N_BITS_BURST_LENGHT = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    message_to_packet_queue_if.slave     bus
);

    localparam int SLOTS  = 2 ** N_BITS_POINTER;
    localparam int CIDX_W = (MAX_BURST_LENGHT > 1) ? $clog2(MAX_BURST_LENGHT) : 1;

    typedef logic [N_BITS_POINTER-1:0]      ptr_t;
    typedef logic [N_BITS_BURST_LENGHT-1:0] cnt_t;

    localparam cnt_t MAX_CNT   = cnt_t'(MAX_BURST_LENGHT);
    localparam ptr_t LAST_SLOT = ptr_t'(QUEUE_WIDTH - 1);

    if (!PACKING_FITS || (SLOTS < QUEUE_WIDTH) ||
        (MAX_BURST_LENGHT >= 2 ** N_BITS_BURST_LENGHT)) begin : g_bad_config
        $error("message_to_packet_queue: inconsistent width configuration");
    end

    ptr_t          r_head, r_tail;
    cnt_t          r_chunk_ptr;
    logic [SLOTS-1:0] r_valid;

    addr_t  r_addr  [SLOTS];
    chunk_t r_data  [SLOTS][MAX_BURST_LENGHT];
    bsel_t  r_sel   [SLOTS][MAX_BURST_LENGHT];
    cnt_t   r_count [SLOTS];

    logic      w_free, w_req, w_store, w_write, w_commit, w_release, w_first;
    cnt_t      w_commit_count;
    packet_t   w_link;
    flit_sel_t w_sel;
    logic      w_unused_sel;

    function automatic flit_sel_t flit_sel(input cnt_t count);
        flit_sel    = '0;
        flit_sel[0] = 1'b1;
        for (int j = 1; j < MAX_PACKET_LENGHT; j++)
            flit_sel[j] = (int'(count) > (j - 1) * CHUNKS_PER_FLIT);
    endfunction

    function automatic ptr_t ptr_next(input ptr_t p);
        ptr_next = (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign w_free         = ~r_valid[r_tail];
    assign w_req          = r_valid[r_head];
    // abort overrides any coincident store or commit
    assign w_store        = bus.store_i & w_free & ~bus.abort_i;
    assign w_write        = w_store & (r_chunk_ptr < MAX_CNT);
    assign w_commit       = bus.message_end_i & w_free & ~bus.abort_i;
    assign w_release      = bus.g_msg_to_pkt_i & w_req;
    assign w_first        = (r_chunk_ptr == '0) & (w_store | w_commit);
    assign w_commit_count = r_chunk_ptr + cnt_t'(w_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_chunk_ptr <= '0;
            r_valid     <= '0;
        end else begin
            if (bus.abort_i || w_commit)
                r_chunk_ptr <= '0;
            else if (w_write)
                r_chunk_ptr <= r_chunk_ptr + 1'b1;
            if (w_commit)
                r_tail <= ptr_next(r_tail);
            if (w_release)
                r_head <= ptr_next(r_head);
            // commit and release never target the same slot
            r_valid <= (r_valid | (w_commit  ? (SLOTS'(1) << r_tail) : '0))
                                & ~(w_release ? (SLOTS'(1) << r_head) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_first)
            r_addr[r_tail] <= bus.address_i;
        if (w_write) begin
            r_data[r_tail][r_chunk_ptr[CIDX_W-1:0]] <= bus.data_i;
            r_sel[r_tail][r_chunk_ptr[CIDX_W-1:0]]  <= bus.sel_i;
        end
        if (w_commit)
            r_count[r_tail] <= w_commit_count;
    end

    // Chunks beyond the committed count are masked so stale or aborted data never leaks out.
    always_comb begin
        w_link = '0;
        w_sel  = '0;
        if (w_req) begin
            w_link[FLIT_WIDTH-1:0] = FLIT_WIDTH'(r_addr[r_head]);
            for (int k = 0; k < MAX_BURST_LENGHT; k++) begin
                if (cnt_t'(k) < r_count[r_head])
                    w_link[FLIT_WIDTH + k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = r_data[r_head][k];
            end
            w_sel = flit_sel(r_count[r_head]);
        end
    end

    assign w_unused_sel       = ^r_sel[r_head][0];
    assign bus.free_slot_o    = w_free;
    assign bus.r_msg_to_pkt_o = w_req;
    assign bus.out_link_o     = w_link;
    assign bus.out_sel_o      = w_sel;

endmodule

// File: tb/tb_message_to_packet_queue.sv
// Directed bench for the MESSAGE2PACKET queue: a vector table for the basic flow,
// then hand-written sequences for fill/wrap, commit+grant, burst overflow and reset.
module tb_message_to_packet_queue;
    import message_to_packet_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    message_to_packet_queue_if bus_if();

    message_to_packet_queue #(.N_BITS_POINTER(3), .N_BITS_BURST_LENGHT(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic      st, en, ab, gr;
        logic [31:0] addr, data;
        logic      exp_req, exp_free;
        logic [4:0] exp_sel;
        logic [159:0] exp_link;
    } vec_t;

    vec_t vecs[13];
    int tests = 0;
    int fails = 0;

    function automatic logic [159:0] pkt(input logic [31:0] addr, input int n, input logic [127:0] ch);
        logic [159:0] p;
        p = '0;
        p[31:0] = addr;
        for (int k = 0; k < n; k++)
            p[32 + k*32 +: 32] = ch[k*32 +: 32];
        return p;
    endfunction

    function automatic vec_t mk(input logic st, en, ab, gr, input logic [31:0] addr, data,
                                input logic req, free, input logic [4:0] sel, input logic [159:0] link);
        vec_t v;
        v.st = st; v.en = en; v.ab = ab; v.gr = gr; v.addr = addr; v.data = data;
        v.exp_req = req; v.exp_free = free; v.exp_sel = sel; v.exp_link = link;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic req, input logic free,
                              input logic [4:0] sel, input logic [159:0] link);
        check({tag, ".req"},  160'(bus_if.r_msg_to_pkt_o), 160'(req));
        check({tag, ".free"}, 160'(bus_if.free_slot_o),    160'(free));
        check({tag, ".sel"},  160'(bus_if.out_sel_o),      160'(sel));
        check({tag, ".link"}, bus_if.out_link_o,           link);
    endtask

    task automatic drive(input logic st, en, ab, gr, input logic [31:0] addr, data);
        bus_if.store_i        = st;
        bus_if.message_end_i  = en;
        bus_if.abort_i        = ab;
        bus_if.g_msg_to_pkt_i = gr;
        bus_if.address_i      = addr;
        bus_if.data_i         = data;
        bus_if.sel_i          = 4'hF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        vecs[0]  = mk(1,0,0,0, 32'h40, 32'hA, 0,1, 5'b00000, '0);
        vecs[1]  = mk(1,0,0,0, 32'h41, 32'hB, 0,1, 5'b00000, '0);
        vecs[2]  = mk(1,1,0,0, 32'h42, 32'hC, 1,1, 5'b01111, pkt(32'h40, 3, {32'h0, 32'hC, 32'hB, 32'hA}));
        vecs[3]  = mk(0,0,0,1, 32'h0,  32'h0, 0,1, 5'b00000, '0);
        vecs[4]  = mk(0,1,0,0, 32'h80, 32'h0, 1,1, 5'b00001, pkt(32'h80, 0, '0));
        vecs[5]  = mk(0,0,0,1, 32'h0,  32'h0, 0,1, 5'b00000, '0);
        vecs[6]  = mk(1,0,0,0, 32'h11, 32'h1, 0,1, 5'b00000, '0);
        vecs[7]  = mk(1,0,0,0, 32'h12, 32'h2, 0,1, 5'b00000, '0);
        vecs[8]  = mk(1,0,1,0, 32'h13, 32'h3, 0,1, 5'b00000, '0);
        vecs[9]  = mk(1,1,0,0, 32'h22, 32'hD, 1,1, 5'b00011, pkt(32'h22, 1, {96'h0, 32'hD}));
        vecs[10] = mk(0,0,0,1, 32'h0,  32'h0, 0,1, 5'b00000, '0);
        vecs[11] = mk(0,1,1,0, 32'h33, 32'h0, 0,1, 5'b00000, '0);
        vecs[12] = mk(0,0,0,1, 32'h0,  32'h0, 0,1, 5'b00000, '0);

        drive(0, 0, 0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 1, 5'b00000, '0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].st, vecs[i].en, vecs[i].ab, vecs[i].gr, vecs[i].addr, vecs[i].data);
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_free,
                       vecs[i].exp_sel, vecs[i].exp_link);
        end

        // Fill every slot, try one extra message, then drain with overlapping commits.
        for (int i = 0; i < QUEUE_WIDTH; i++) begin
            drive(1, 1, 0, 0, 32'h200 + i, 32'h100 + i);
            tick();
        end
        expect_out("full", 1, 0, 5'b00011, pkt(32'h200, 1, {96'h0, 32'h100}));
        drive(1, 1, 0, 0, 32'h2EE, 32'hEE);
        tick();
        expect_out("full_ignored", 1, 0, 5'b00011, pkt(32'h200, 1, {96'h0, 32'h100}));
        drive(0, 0, 0, 1, 32'h0, 32'h0);
        tick();
        expect_out("full_release", 1, 1, 5'b00011, pkt(32'h201, 1, {96'h0, 32'h101}));
        for (int i = 4; i < 8; i++) begin
            drive(1, 1, 0, 1, 32'h200 + i, 32'h100 + i);
            tick();
            expect_out($sformatf("wrap%0d", i), 1, 1, 5'b00011,
                       pkt(32'h200 + i - 2, 1, {96'h0, 32'(32'h100 + i - 2)}));
        end
        for (int i = 6; i < 8; i++) begin
            drive(0, 0, 0, 1, 32'h0, 32'h0);
            tick();
            expect_out($sformatf("drain%0d", i), 1, 1, 5'b00011,
                       pkt(32'h200 + i, 1, {96'h0, 32'(32'h100 + i)}));
        end
        drive(0, 0, 0, 1, 32'h0, 32'h0);
        tick();
        expect_out("drain_empty", 0, 1, 5'b00000, '0);

        // Commit and grant in the same cycle with one packet queued.
        drive(1, 1, 0, 0, 32'h400, 32'h71);
        tick();
        expect_out("one_queued", 1, 1, 5'b00011, pkt(32'h400, 1, {96'h0, 32'h71}));
        drive(1, 1, 0, 1, 32'h410, 32'h72);
        tick();
        expect_out("commit_grant", 1, 1, 5'b00011, pkt(32'h410, 1, {96'h0, 32'h72}));
        drive(0, 0, 0, 1, 32'h0, 32'h0);
        tick();
        expect_out("commit_grant_drain", 0, 1, 5'b00000, '0);

        // Burst longer than a slot: extra chunks dropped, count saturates.
        for (int i = 0; i < MAX_BURST_LENGHT + 2; i++) begin
            drive(1, 0, 0, 0, 32'h90 + i, 32'h50 + i);
            tick();
        end
        drive(0, 1, 0, 0, 32'h0, 32'h0);
        tick();
        expect_out("overflow", 1, 1, 5'b11111,
                   pkt(32'h90, 4, {32'h53, 32'h52, 32'h51, 32'h50}));
        drive(0, 0, 0, 1, 32'h0, 32'h0);
        tick();
        expect_out("overflow_drain", 0, 1, 5'b00000, '0);

        // Reset with a packet queued and a message half assembled.
        drive(1, 1, 0, 0, 32'h300, 32'h61);
        tick();
        expect_out("pre_reset", 1, 1, 5'b00011, pkt(32'h300, 1, {96'h0, 32'h61}));
        drive(1, 0, 0, 0, 32'h310, 32'h62);
        tick();
        drive(1, 0, 0, 0, 32'h311, 32'h63);
        rst = 1'b1;
        tick();
        expect_out("mid_reset", 0, 1, 5'b00000, '0);
        rst = 1'b0;
        drive(1, 1, 0, 0, 32'h320, 32'h64);
        tick();
        expect_out("post_reset", 1, 1, 5'b00011, pkt(32'h320, 1, {96'h0, 32'h64}));
        drive(0, 0, 0, 1, 32'h0, 32'h0);
        tick();
        expect_out("post_reset_drain", 0, 1, 5'b00000, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/message_to_packet_queue.md
# message_to_packet_queue

Queue of the MESSAGE2PACKET stage in NIC_base. It assembles messages arriving chunk by chunk from the WISHBONE slave interface into packet-sized slots. It stores them FIFO-ordered and offers each complete packet to the output port with a request/grant handshake. It is the bus-to-NoC counterpart of the PACKET2MESSAGE queue.

## Interface
Parameters:
- N_BITS_POINTER, 3: width of head/tail pointers; 2^N_BITS_POINTER >= `QUEUE_WIDTH
- N_BITS_BURST_LENGHT, 7: width of chunk pointer/count; must hold `MAX_BURST_LENGHT

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- store_i  in  1  slave interface: data_i/sel_i is the next chunk of the message under assembly
- address_i  in  `BUS_ADDRESS_WIDTH  head flit; captured on the first store_i or message_end_i of a message
- data_i  in  `BUS_DATA_WIDTH  chunk payload
- sel_i  in  `BUS_SEL_WIDTH  byte enables of chunk; stored but not used to build out_sel_o
- message_end_i  in  1  commit the message under assembly; may coincide with store_i of the last chunk
- abort_i  in  1  discard the message under assembly (bus retry/error)
- free_slot_o  out  1  tail slot empty; the slave may start or continue a message
- out_link_o  out  `MAX_PACKET_LENGHT*`FLIT_WIDTH  head packet: flit 0 is the head; data chunks follow, packed from flit 1
- out_sel_o  out  `MAX_PACKET_LENGHT  bit j high: flit j is valid
- r_msg_to_pkt_o  out  1  request to the output port; a packet is available at head
- g_msg_to_pkt_i  in  1  grant; the head packet has been taken

## Operation
- Storage: `QUEUE_WIDTH slots. Each slot holds a head flit, `MAX_BURST_LENGHT data chunks, a chunk count and a valid bit. The head pointer and the tail pointer each wrap from `QUEUE_WIDTH-1 to 0.
- Assembly happens in the tail slot, tracked by chunk_ptr.
  - store_i with free_slot_o=1: write chunk_ptr's data position, then chunk_ptr+1.
  - If chunk_ptr is already `MAX_BURST_LENGHT, the chunk is dropped and chunk_ptr saturates.
  - store_i while free_slot_o=0 is ignored.
- Commit: message_end_i with free_slot_o=1.
  - Store the count, which includes a coincident chunk.
  - Set valid[tail], advance tail, clear chunk_ptr.
  - A commit with zero chunks produces a head-only packet (read request).
- Abort: abort_i clears chunk_ptr only; tail and valid are unchanged. abort_i wins over a coincident store_i or message_end_i.
- Packing: CHUNKS_PER_FLIT = `FLIT_WIDTH/`BUS_DATA_WIDTH (integer >= 1).
  - Chunk k goes to bits [`FLIT_WIDTH + (k+1)*`BUS_DATA_WIDTH - 1 : `FLIT_WIDTH + k*`BUS_DATA_WIDTH].
  - out_sel_o[0] = 1. For j >= 1, out_sel_o[j] = (count > (j-1)*CHUNKS_PER_FLIT).
- Output gating: r_msg_to_pkt_o = valid[head]. While it is 0, out_link_o and out_sel_o are forced to 0.
- Release: g_msg_to_pkt_i with r_msg_to_pkt_o=1 clears valid[head] and advances head. A grant while the request is low is ignored.
- Commit and release in the same cycle both apply, on different slots.

## Timing
- Reset values: r_msg_to_pkt_o=0, out_sel_o=0, out_link_o=0, free_slot_o=1. Head, tail, chunk_ptr and all valid bits are 0.
- Commit at edge N: r_msg_to_pkt_o high from cycle N+1 if the queue was empty. free_slot_o reflects the new tail from N+1.
- Grant sampled at edge N: the next packet, or the low request, is visible at N+1. The minimum request-to-release period is 1 cycle, so back-to-back grants drain one packet per cycle.
- free_slot_o and the outputs are combinational from registers only; there is no input-to-output path.
- Full queue: after `QUEUE_WIDTH commits without a release, valid[tail]=1 and free_slot_o=0. Storing resumes the cycle after the release of that slot.
- Reset mid-assembly or mid-handshake: all slots are invalidated and the partial message is lost.

## Structure
- The shared defines header gains CHUNKS_PER_FLIT.
- It also gains a check that `FLIT_WIDTH + `MAX_BURST_LENGHT*`BUS_DATA_WIDTH <= `MAX_PACKET_LENGHT*`FLIT_WIDTH.
- All other widths come from existing defines.
- Single module; no sub-module is warranted. The flit-select computation is a local function.

## Test plan
- Reset, then commit 3 chunks (0xA, 0xB, 0xC) with address 0x40 and CHUNKS_PER_FLIT=1: r_msg_to_pkt_o=1 next cycle, out_sel_o=...01111, flit0=0x40, flits1-3=A,B,C. Grant: request drops in 1 cycle.
- message_end_i alone, address 0x80: head-only packet, out_sel_o=...0001.
- Fill all `QUEUE_WIDTH slots: free_slot_o=0 and extra store_i is ignored. One grant: free_slot_o=1 next cycle. Wrap order is preserved across 2*`QUEUE_WIDTH messages.
- Store 2 chunks then abort_i, then commit 1 chunk 0xD: packet has count 1 and flit1=0xD, with no residue from the aborted chunks.
- Simultaneous commit and grant with 1 queued: the next packet is presented at N+1 and r_msg_to_pkt_o stays high.
- Store `MAX_BURST_LENGHT+2 chunks then commit: the extra chunks are dropped and all flits are valid. Reset asserted mid-burst: all outputs return to their reset values next cycle.
